// File: rtl/ddr3_tg_pkg.sv
// Shared types and helpers for the DDR3 AXI traffic generator: FSM states,
// AXI encodings and the address-derived test pattern.
package ddr3_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } tg_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [31:0] tg_pattern(input logic [31:0] addr, input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/ddr3_tg_checker.sv
// Scores write responses and read beats, keeps a saturating error count and
// captures the address of the first failing beat (or burst, for B errors).
module ddr3_tg_checker
  import ddr3_tg_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'h1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        b_hs_i,
  input  logic [1:0]  bresp_i,
  input  logic [3:0]  bid_i,
  input  logic [31:0] b_addr_i,
  input  logic        r_hs_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic [3:0]  rid_i,
  input  logic        rlast_i,
  input  logic [31:0] exp_data_i,
  input  logic        exp_last_i,
  input  logic [31:0] beat_addr_i,
  output logic [15:0] err_count_o,
  output logic [31:0] first_err_addr_o
);

  logic [15:0] err_count_q, err_count_d;
  logic [31:0] first_err_addr_q, first_err_addr_d;
  logic        b_err, r_err;
  logic [31:0] ev_addr;

  always_comb begin
    b_err = b_hs_i && ((bresp_i != AXI_RESP_OKAY) || (bid_i != AXI_ID));
    // Several faults on one beat still count as a single error.
    r_err = r_hs_i && ((rdata_i != exp_data_i) || (rresp_i != AXI_RESP_OKAY) ||
                       (rid_i != AXI_ID) || (rlast_i != exp_last_i));
    ev_addr          = b_hs_i ? b_addr_i : beat_addr_i;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    if (clr_i) begin
      err_count_d      = 16'd0;
      first_err_addr_d = 32'd0;
    end else if (b_err || r_err) begin
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      if (err_count_q == 16'd0) first_err_addr_d = ev_addr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_count_q      <= 16'd0;
      first_err_addr_q <= 32'd0;
    end else begin
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
    end
  end

  assign err_count_o      = err_count_q;
  assign first_err_addr_o = first_err_addr_q;

endmodule

// File: rtl/ddr3_axi_traffic_gen.sv
// AXI4 master self-test: writes NUM_BURSTS INCR bursts of an address-derived
// pattern, reads them back and reports pass/fail through the checker.
module ddr3_axi_traffic_gen
  import ddr3_tg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          BURST_LEN  = 8,
  parameter int          NUM_BURSTS = 16,
  parameter logic [3:0]  AXI_ID     = 4'h1,
  parameter logic [31:0] SEED       = 32'hA5A5_0001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_count_o,
  output logic [31:0] first_err_addr_o,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_awaddr,
  output logic [3:0]  axi_awid,
  output logic [7:0]  axi_awlen,
  output logic [1:0]  axi_awburst,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wlast,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  input  logic [1:0]  axi_bresp,
  input  logic [3:0]  axi_bid,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [31:0] axi_araddr,
  output logic [3:0]  axi_arid,
  output logic [7:0]  axi_arlen,
  output logic [1:0]  axi_arburst,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic [3:0]  axi_rid,
  input  logic        axi_rlast
);

  localparam int              BW          = $clog2(NUM_BURSTS + 1);
  localparam logic [31:0]     BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [7:0]      LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [BW-1:0]   LAST_BURST  = BW'(NUM_BURSTS - 1);

  function automatic logic [31:0] burst_addr(input logic [BW-1:0] k);
    return BASE_ADDR + 32'(k) * BURST_BYTES;
  endfunction

  function automatic logic [31:0] beat_off(input logic [7:0] b);
    return {22'd0, b, 2'b00};
  endfunction

  tg_state_e      state_q, state_d;
  logic [7:0]     beat_q, beat_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic           awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic           bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [31:0]    awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic           start_ok, b_hs, r_hs, r_end;
  logic [31:0]    rd_beat_addr;
  logic [7:0]     beat_nxt;
  logic [15:0]    err_count;

  always_comb begin
    start_ok     = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    b_hs         = (state_q == ST_WR_RESP) && axi_bvalid && bready_q;
    r_hs         = (state_q == ST_RD_DATA) && axi_rvalid && rready_q;
    // An early rlast terminates the burst as well as counting as an error.
    r_end        = r_hs && (axi_rlast || (beat_q == LAST_BEAT));
    rd_beat_addr = araddr_q + beat_off(beat_q);
    beat_nxt     = beat_q + 8'd1;

    state_d   = state_q;   beat_d    = beat_q;    burst_d  = burst_q;
    awvalid_d = awvalid_q; awaddr_d  = awaddr_q;
    wvalid_d  = wvalid_q;  wdata_d   = wdata_q;   wlast_d  = wlast_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q; araddr_d  = araddr_q;  rready_d = rready_q;
    busy_d    = busy_q;    done_d    = done_q;

    case (state_q)
      ST_IDLE, ST_DONE: if (start_ok) begin
        state_d   = ST_WR_ADDR;
        burst_d   = '0;
        awvalid_d = 1'b1;
        awaddr_d  = burst_addr('0);
        busy_d    = 1'b1;
        done_d    = 1'b0;
      end
      ST_WR_ADDR: if (axi_awready) begin
        state_d   = ST_WR_DATA;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b1;
        beat_d    = 8'd0;
        wdata_d   = tg_pattern(awaddr_q, SEED);
        wlast_d   = (LAST_BEAT == 8'd0);
      end
      ST_WR_DATA: if (axi_wready) begin
        if (wlast_q) begin
          state_d  = ST_WR_RESP;
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
          bready_d = 1'b1;
        end else begin
          beat_d  = beat_nxt;
          wdata_d = tg_pattern(awaddr_q + beat_off(beat_nxt), SEED);
          wlast_d = (beat_nxt == LAST_BEAT);
        end
      end
      ST_WR_RESP: if (axi_bvalid) begin
        bready_d = 1'b0;
        if (burst_q == LAST_BURST) begin
          state_d   = ST_RD_ADDR;
          burst_d   = '0;
          arvalid_d = 1'b1;
          araddr_d  = burst_addr('0);
        end else begin
          state_d   = ST_WR_ADDR;
          burst_d   = burst_q + BW'(1);
          awvalid_d = 1'b1;
          awaddr_d  = burst_addr(burst_q + BW'(1));
        end
      end
      ST_RD_ADDR: if (axi_arready) begin
        state_d   = ST_RD_DATA;
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        beat_d    = 8'd0;
      end
      ST_RD_DATA: if (r_end) begin
        rready_d = 1'b0;
        if (burst_q == LAST_BURST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d   = ST_RD_ADDR;
          burst_d   = burst_q + BW'(1);
          arvalid_d = 1'b1;
          araddr_d  = burst_addr(burst_q + BW'(1));
        end
      end else if (r_hs) begin
        beat_d = beat_nxt;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE; beat_q  <= 8'd0;  burst_q  <= '0;
      awvalid_q <= 1'b0;    awaddr_q <= 32'd0;
      wvalid_q  <= 1'b0;    wdata_q <= 32'd0; wlast_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;    araddr_q <= 32'd0; rready_q <= 1'b0;
      busy_q    <= 1'b0;    done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;   beat_q   <= beat_d;   burst_q  <= burst_d;
      awvalid_q <= awvalid_d; awaddr_q <= awaddr_d;
      wvalid_q  <= wvalid_d;  wdata_q  <= wdata_d;  wlast_q  <= wlast_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d; araddr_q <= araddr_d; rready_q <= rready_d;
      busy_q    <= busy_d;    done_q   <= done_d;
    end
  end

  ddr3_tg_checker #(.AXI_ID(AXI_ID)) u_checker (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clr_i            (start_ok),
    .b_hs_i           (b_hs),
    .bresp_i          (axi_bresp),
    .bid_i            (axi_bid),
    .b_addr_i         (awaddr_q),
    .r_hs_i           (r_hs),
    .rdata_i          (axi_rdata),
    .rresp_i          (axi_rresp),
    .rid_i            (axi_rid),
    .rlast_i          (axi_rlast),
    .exp_data_i       (tg_pattern(rd_beat_addr, SEED)),
    .exp_last_i       (beat_q == LAST_BEAT),
    .beat_addr_i      (rd_beat_addr),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr_o)
  );

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = done_q && (err_count == 16'd0);
  assign err_count_o = err_count;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awid    = AXI_ID;
  assign axi_awlen   = LAST_BEAT;
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = 4'hF;
  assign axi_wlast   = wlast_q;
  assign axi_bready  = bready_q;
  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = araddr_q;
  assign axi_arid    = AXI_ID;
  assign axi_arlen   = LAST_BEAT;
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_rready  = rready_q;

endmodule
